calendar_date_setter: RTL and testbench

User-facing date entry controller that writes the calendar's overwrite interface. It captures the current date from the calendar, lets the operator step through day, month and year fields with debounced buttons, and keeps every intermediate value a legal date. On commit it presents the new date word and issues a single-cycle overwrite pulse that the calendar consumes as `date_in`/`date_ow`.

---
 rtl/calendar_date_setter.sv | 146 ++++++++++++++
 tb/tb_calendar_date_setter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/calendar_date_setter.sv
// Date entry controller: captures the live date, lets the operator edit day/month/year
// while keeping the value legal, then issues a one-cycle overwrite strobe on commit.
module calendar_date_setter #(
    parameter int YEARRES = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [YEARRES+8:0] date_cur,
    input  logic               btn_mode,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_cancel,
    output logic [YEARRES+8:0] date_set,
    output logic               date_ow,
    output logic               editing,
    output logic [1:0]         field
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DAY,
        S_MONTH,
        S_YEAR,
        S_COMMIT
    } state_t;

    state_t               state, state_nx;
    logic [4:0]           d_e, d_nx;
    logic [3:0]           m_e, m_nx;
    logic [YEARRES-1:0]   y_e, y_nx;
    logic                 ow_nx;

    logic [4:0]           cur_d;
    logic [3:0]           cur_m, san_m;
    logic [YEARRES-1:0]   cur_y;
    logic [3:0]           m_tmp;
    logic [YEARRES-1:0]   y_tmp;
    logic [4:0]           dmax;
    logic                 step;

    // Leap rule matches the calendar: every year divisible by 4.
    function automatic logic [4:0] month_len(input logic [3:0] m, input logic [1:0] ylo);
        case (m)
            4'd2:                    return (ylo == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    function automatic logic [4:0] min_day(input logic [4:0] a, input logic [4:0] b);
        return (a < b) ? a : b;
    endfunction

    assign cur_d = date_cur[YEARRES+8:YEARRES+4];
    assign cur_m = date_cur[YEARRES+3:YEARRES];
    assign cur_y = date_cur[YEARRES-1:0];
    assign san_m = (cur_m == 4'd0 || cur_m > 4'd12) ? 4'd1 : cur_m;
    assign step  = btn_up ^ btn_down;

    always_comb begin
        state_nx = state;
        d_nx     = d_e;
        m_nx     = m_e;
        y_nx     = y_e;
        ow_nx    = 1'b0;
        m_tmp    = m_e;
        y_tmp    = y_e;
        dmax     = month_len(m_e, y_e[1:0]);
        case (state)
            S_IDLE: begin
                if (btn_mode) begin
                    state_nx = S_DAY;
                    m_nx     = san_m;
                    y_nx     = cur_y;
                    d_nx     = (cur_d == 5'd0) ? 5'd1
                             : min_day(cur_d, month_len(san_m, cur_y[1:0]));
                end
            end
            S_DAY, S_MONTH, S_YEAR: begin
                if (btn_cancel) begin
                    state_nx = S_IDLE;
                end else if (btn_mode) begin
                    case (state)
                        S_DAY:   state_nx = S_MONTH;
                        S_MONTH: state_nx = S_YEAR;
                        default: begin
                            state_nx = S_COMMIT;
                            ow_nx    = 1'b1;
                        end
                    endcase
                end else if (step) begin
                    case (state)
                        S_DAY: begin
                            if (btn_up) d_nx = (d_e >= dmax) ? 5'd1 : d_e + 5'd1;
                            else        d_nx = (d_e <= 5'd1) ? dmax : d_e - 5'd1;
                        end
                        S_MONTH: begin
                            if (btn_up) m_tmp = (m_e >= 4'd12) ? 4'd1 : m_e + 4'd1;
                            else        m_tmp = (m_e <= 4'd1) ? 4'd12 : m_e - 4'd1;
                            m_nx = m_tmp;
                            d_nx = min_day(d_e, month_len(m_tmp, y_e[1:0]));
                        end
                        default: begin
                            // Year wraps naturally modulo 2^YEARRES.
                            y_tmp = btn_up ? y_e + 1'b1 : y_e - 1'b1;
                            y_nx  = y_tmp;
                            d_nx  = min_day(d_e, month_len(m_e, y_tmp[1:0]));
                        end
                    endcase
                end
            end
            S_COMMIT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            d_e     <= 5'd1;
            m_e     <= 4'd1;
            y_e     <= '0;
            date_ow <= 1'b0;
        end else begin
            state   <= state_nx;
            d_e     <= d_nx;
            m_e     <= m_nx;
            y_e     <= y_nx;
            date_ow <= ow_nx;
        end
    end

    assign date_set = {d_e, m_e, y_e};
    assign editing  = (state == S_DAY) || (state == S_MONTH) || (state == S_YEAR);

    always_comb begin
        field = 2'd0;
        case (state)
            S_DAY:   field = 2'd1;
            S_MONTH: field = 2'd2;
            S_YEAR:  field = 2'd3;
            default: field = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_calendar_date_setter.sv
// Bench for calendar_date_setter: directed scenarios plus random button traffic,
// every cycle compared against a field-level date model.
module tb_calendar_date_setter;
    localparam int YR = 12;
    localparam int YMOD = 1 << YR;

    logic          clk = 1'b0;
    logic          rst, btn_mode, btn_up, btn_down, btn_cancel;
    logic [YR+8:0] date_cur, date_set;
    logic          date_ow, editing;
    logic [1:0]    field;

    int checks = 0;
    int errors = 0;
    // model: st 0 idle, 1 day, 2 month, 3 year, 4 commit
    int st = 0, md = 1, mm = 1, my = 0;

    always #5 clk = ~clk;

    calendar_date_setter #(.YEARRES(YR)) dut (
        .clk(clk), .rst(rst), .date_cur(date_cur),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_cancel(btn_cancel),
        .date_set(date_set), .date_ow(date_ow), .editing(editing), .field(field)
    );

    function automatic int mlen(int m, int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cur(input int d, input int m, input int y);
        date_cur = {d[4:0], m[3:0], y[YR-1:0]};
    endtask

    task automatic model(input bit r, input bit mo, input bit u, input bit dn, input bit c);
        int cd, cm, cy;
        cd = int'(date_cur[YR+8:YR+4]);
        cm = int'(date_cur[YR+3:YR]);
        cy = int'(date_cur[YR-1:0]);
        if (r) begin
            st = 0; md = 1; mm = 1; my = 0;
        end else if (st == 0) begin
            if (mo) begin
                mm = (cm == 0 || cm > 12) ? 1 : cm;
                my = cy;
                md = (cd == 0) ? 1 : (cd > mlen(mm, my) ? mlen(mm, my) : cd);
                st = 1;
            end
        end else if (st == 4) begin
            st = 0;
        end else if (c) begin
            st = 0;
        end else if (mo) begin
            st = st + 1;
        end else if (u != dn) begin
            if (st == 1) begin
                if (u) md = (md == mlen(mm, my)) ? 1 : md + 1;
                else   md = (md == 1) ? mlen(mm, my) : md - 1;
            end else begin
                if (st == 2) mm = u ? (mm % 12) + 1 : ((mm + 10) % 12) + 1;
                else         my = u ? (my + 1) % YMOD : (my + YMOD - 1) % YMOD;
                if (md > mlen(mm, my)) md = mlen(mm, my);
            end
        end
    endtask

    task automatic step(input bit r, input bit mo, input bit u, input bit dn, input bit c);
        logic [YR+8:0] ew;
        rst = r; btn_mode = mo; btn_up = u; btn_down = dn; btn_cancel = c;
        @(posedge clk);
        model(r, mo, u, dn, c);
        @(negedge clk);
        ew = {md[4:0], mm[3:0], my[YR-1:0]};
        check("date_set", 32'(date_set), 32'(ew));
        check("date_ow", 32'(date_ow), 32'(st == 4));
        check("editing", 32'(editing), 32'(st >= 1 && st <= 3));
        check("field", 32'(field), (st >= 1 && st <= 3) ? st : 0);
        rst = 0; btn_mode = 0; btn_up = 0; btn_down = 0; btn_cancel = 0;
    endtask

    task automatic mode();   step(0, 1, 0, 0, 0); endtask
    task automatic up();     step(0, 0, 1, 0, 0); endtask
    task automatic down();   step(0, 0, 0, 1, 0); endtask
    task automatic cancel(); step(0, 0, 0, 0, 1); endtask

    initial begin
        rst = 1; btn_mode = 0; btn_up = 0; btn_down = 0; btn_cancel = 0;
        set_cur(31, 1, 2021);
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_word", 32'(date_set), 32'({5'd1, 4'd1, 12'd0}));
        up(); down(); cancel(); step(0, 0, 1, 1, 1);

        // Jan 31 -> Feb clamps to 28 in a non-leap year, then commit
        set_cur(31, 1, 2021);
        mode(); mode(); up(); mode(); mode();
        check("commit_word", 32'(date_set), 32'({5'd28, 4'd2, 12'd2021}));
        step(0, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
        cancel();

        // Feb 29 2020, year up clamps, year down keeps 28
        set_cur(29, 2, 2020);
        mode(); mode(); mode(); up(); down();
        check("leap_clamp_day", 32'(date_set[YR+8:YR+4]), 32'd28);
        cancel();

        // Sanitizing and wraps
        set_cur(0, 13, 5);
        mode();
        check("sanitize", 32'(date_set), 32'({5'd1, 4'd1, 12'd5}));
        down(); up(); mode(); down(); mode();
        for (int i = 0; i < 6; i++) down();
        check("year_wrap", 32'(date_set[YR-1:0]), 32'd4095);
        up();
        cancel();

        // Simultaneous buttons and cancel in MONTH
        set_cur(15, 6, 1999);
        mode(); mode(); step(0, 0, 1, 1, 0); step(0, 1, 1, 0, 0); cancel();
        mode(); mode(); cancel(); step(0, 0, 0, 0, 0);

        // Reset during COMMIT, reset in YEAR with mode
        mode(); mode(); mode(); mode();
        step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        mode(); mode(); mode(); step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            set_cur(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, YMOD - 1)));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 11) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
